// File: rtl/gem_ext_fifo_rx.sv
// gem_ext_fifo_rx: GEM receive byte stream to AXI-Stream with frame-aware buffering.
// A circular buffer of DEPTH {data, last, user} entries sits between the unstallable GEM
// write side and the AXI-Stream master. The frame FSM guarantees one terminating entry
// per started frame by truncating before the buffer runs out of room.
// Optional macro GEM_EXT_FIFO_RX_STATS_EN adds saturating good/bad frame counters.
module gem_ext_fifo_rx #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  gem_rx_w_data,
  input  logic        gem_rx_w_wr,
  input  logic        gem_rx_w_sop,
  input  logic        gem_rx_w_eop,
  input  logic        gem_rx_w_err,
  input  logic        gem_rx_w_overflow,
  input  logic        gem_rx_w_flush,
  input  logic [44:0] gem_rx_w_status,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [44:0] rx_frame_status,
  output logic        rx_frame_status_valid,
  output logic        rx_buf_overflow
`ifdef GEM_EXT_FIFO_RX_STATS_EN
  ,
  output logic [31:0] rx_good_frames,
  output logic [31:0] rx_bad_frames
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full       = CW'(DEPTH);
  localparam logic [CW-1:0] OneFree    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] TruncLevel = CW'(DEPTH - 2);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  // Entry layout: {data[7:0], last, user}
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q, state_d;
  logic          sticky_q, sticky_d;
  logic          ovf_now;
  logic          wr_en, rd_en;
  logic [9:0]    wr_entry;
  logic          ovf_pulse, stat_latch;
  logic [44:0]   status_q;
  logic          status_valid_q, buf_ovf_q;
  logic [9:0]    head;

  assign rd_en   = (count_q != '0) && m_axis_tready;
  assign ovf_now = sticky_q | gem_rx_w_overflow;

  // Frame FSM: decides what (if anything) is written this cycle and the next state.
  always_comb begin
    state_d    = state_q;
    sticky_d   = sticky_q;
    wr_en      = 1'b0;
    wr_entry   = '0;
    ovf_pulse  = 1'b0;
    stat_latch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gem_rx_w_wr && gem_rx_w_sop) begin
          if (count_q == Full) begin
            ovf_pulse = 1'b1;
          end else if (count_q == OneFree && !gem_rx_w_eop) begin
            // Only one slot left: the first byte must also be the terminator.
            wr_en     = 1'b1;
            wr_entry  = {gem_rx_w_data, 1'b1, 1'b1};
            ovf_pulse = 1'b1;
            state_d   = StDrop;
          end else begin
            wr_en    = 1'b1;
            wr_entry = {gem_rx_w_data, gem_rx_w_eop, gem_rx_w_eop & gem_rx_w_err};
            if (gem_rx_w_eop) begin
              stat_latch = 1'b1;
            end else begin
              state_d = StFrame;
            end
          end
        end
      end
      StFrame: begin
        sticky_d = ovf_now;
        if (gem_rx_w_flush) begin
          wr_en    = 1'b1;
          wr_entry = {8'h00, 1'b1, 1'b1};
          state_d  = StIdle;
          sticky_d = 1'b0;
        end else if (gem_rx_w_wr) begin
          wr_en = 1'b1;
          if (gem_rx_w_sop) begin
            // New frame while one is open: close the old one as bad, drop the new one.
            wr_entry = {gem_rx_w_data, 1'b1, 1'b1};
            state_d  = gem_rx_w_eop ? StIdle : StDrop;
            sticky_d = 1'b0;
          end else if (count_q >= TruncLevel) begin
            // This byte would bring occupancy to DEPTH-1: it becomes the terminator.
            wr_entry   = {gem_rx_w_data, 1'b1, 1'b1};
            ovf_pulse  = 1'b1;
            stat_latch = gem_rx_w_eop;
            state_d    = gem_rx_w_eop ? StIdle : StDrop;
            sticky_d   = 1'b0;
          end else if (gem_rx_w_eop) begin
            wr_entry   = {gem_rx_w_data, 1'b1, gem_rx_w_err | ovf_now};
            stat_latch = 1'b1;
            state_d    = StIdle;
            sticky_d   = 1'b0;
          end else begin
            wr_entry = {gem_rx_w_data, 1'b0, 1'b0};
          end
        end
      end
      StDrop: begin
        if (gem_rx_w_flush || (gem_rx_w_wr && gem_rx_w_eop)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, pointers, occupancy and registered strobes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= StIdle;
      sticky_q       <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      buf_ovf_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q        <= count_q + CW'(wr_en) - CW'(rd_en);
      status_valid_q <= stat_latch;
      buf_ovf_q      <= ovf_pulse;
      if (stat_latch) status_q <= gem_rx_w_status;
    end
  end

  // Buffer storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head of buffer drives the stream; fields read as zero while empty.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    m_axis_tvalid = (count_q != '0);
    m_axis_tdata  = m_axis_tvalid ? head[9:2] : 8'h00;
    m_axis_tlast  = m_axis_tvalid & head[1];
    m_axis_tuser  = m_axis_tvalid & head[0];
  end

  assign rx_frame_status       = status_q;
  assign rx_frame_status_valid = status_valid_q;
  assign rx_buf_overflow       = buf_ovf_q;

`ifdef GEM_EXT_FIFO_RX_STATS_EN
  logic [31:0] good_q, bad_q;

  // Count terminating entries as they enter the buffer, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (wr_en && wr_entry[1]) begin
      if (!wr_entry[0] && good_q != '1) good_q <= good_q + 32'd1;
      if (wr_entry[0] && bad_q != '1)   bad_q  <= bad_q + 32'd1;
    end
  end

  assign rx_good_frames = good_q;
  assign rx_bad_frames  = bad_q;
`endif

endmodule

// File: tb/tb_gem_ext_fifo_rx.sv
// Self-checking bench for gem_ext_fifo_rx: queue-based frame model checked every cycle,
// directed frame scenarios with literal expectations, then randomized traffic.
module tb_gem_ext_fifo_rx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  wdata;
  logic        wr, sop, eop, err, ovf_in, flush;
  logic [44:0] status;
  logic [7:0]  tdata;
  logic        tvalid, tready, tlast, tuser;
  logic [44:0] fstat;
  logic        fstat_v, buf_ovf;
`ifdef GEM_EXT_FIFO_RX_STATS_EN
  logic [31:0] good_frames, bad_frames;
`endif

  always #5 clk = ~clk;

  gem_ext_fifo_rx #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .gem_rx_w_data         (wdata),
    .gem_rx_w_wr           (wr),
    .gem_rx_w_sop          (sop),
    .gem_rx_w_eop          (eop),
    .gem_rx_w_err          (err),
    .gem_rx_w_overflow     (ovf_in),
    .gem_rx_w_flush        (flush),
    .gem_rx_w_status       (status),
    .m_axis_tdata          (tdata),
    .m_axis_tvalid         (tvalid),
    .m_axis_tready         (tready),
    .m_axis_tlast          (tlast),
    .m_axis_tuser          (tuser),
    .rx_frame_status       (fstat),
    .rx_frame_status_valid (fstat_v),
    .rx_buf_overflow       (buf_ovf)
`ifdef GEM_EXT_FIFO_RX_STATS_EN
    ,
    .rx_good_frames        (good_frames),
    .rx_bad_frames         (bad_frames)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  int          m_mode;  // 0 idle, 1 in frame, 2 dropping
  logic        m_sticky;
  logic        e_ovf, e_sv;
  logic [44:0] e_status;
  int unsigned e_good, e_bad;
  bit          model_live = 1'b0;

  int checks = 0;
  int errors = 0;

  // Observation counters for directed scenarios
  int       mon_bytes, mon_lasts, mon_last_pos, mon_ovf, mon_sv;
  logic [7:0] mon_last_data;
  logic     mon_last_user;

  function automatic ent_t mk(logic [7:0] d, logic l, logic u);
    ent_t e;
    e.d = d;
    e.l = l;
    e.u = u;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(ent_t e);
    q.push_back(e);
    if (e.l) begin
      if (e.u) begin
        if (e_bad != 32'hFFFF_FFFF) e_bad++;
      end else begin
        if (e_good != 32'hFFFF_FFFF) e_good++;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    int   n;
    logic on;
    if (!rstn) begin
      q.delete();
      m_mode     = 0;
      m_sticky   = 1'b0;
      e_ovf      = 1'b0;
      e_sv       = 1'b0;
      e_status   = '0;
      e_good     = 0;
      e_bad      = 0;
      model_live = 1'b1;
      return;
    end
    n     = q.size();
    e_ovf = 1'b0;
    e_sv  = 1'b0;
    if (n > 0 && tready) void'(q.pop_front());
    on = m_sticky | ovf_in;
    case (m_mode)
      0: if (wr && sop) begin
        if (n == DEPTH) begin
          e_ovf = 1'b1;
        end else if (n == DEPTH - 1 && !eop) begin
          push(mk(wdata, 1'b1, 1'b1));
          e_ovf  = 1'b1;
          m_mode = 2;
        end else begin
          push(mk(wdata, eop, eop & err));
          if (eop) begin
            e_sv = 1'b1;
            e_status = status;
          end else begin
            m_mode = 1;
          end
        end
      end
      1: begin
        m_sticky = on;
        if (flush) begin
          push(mk(8'h00, 1'b1, 1'b1));
          m_mode = 0;
          m_sticky = 1'b0;
        end else if (wr) begin
          if (sop) begin
            push(mk(wdata, 1'b1, 1'b1));
            m_mode = eop ? 0 : 2;
            m_sticky = 1'b0;
          end else if (n >= DEPTH - 2) begin
            push(mk(wdata, 1'b1, 1'b1));
            e_ovf = 1'b1;
            if (eop) begin
              e_sv = 1'b1;
              e_status = status;
            end
            m_mode = eop ? 0 : 2;
            m_sticky = 1'b0;
          end else if (eop) begin
            push(mk(wdata, 1'b1, err | on));
            e_sv = 1'b1;
            e_status = status;
            m_mode = 0;
            m_sticky = 1'b0;
          end else begin
            push(mk(wdata, 1'b0, 1'b0));
          end
        end
      end
      default: if (flush || (wr && eop)) m_mode = 0;
    endcase
  endtask

  task automatic compare();
    ent_t h;
    if (!model_live) return;
    h = (q.size() != 0) ? q[0] : mk(8'h00, 1'b0, 1'b0);
    check("tvalid", 64'(tvalid), 64'(q.size() != 0));
    check("tdata", 64'(tdata), 64'(h.d));
    check("tlast", 64'(tlast), 64'(h.l));
    check("tuser", 64'(tuser), 64'(h.u));
    check("buf_overflow", 64'(buf_ovf), 64'(e_ovf));
    check("status_valid", 64'(fstat_v), 64'(e_sv));
    check("frame_status", 64'(fstat), 64'(e_status));
`ifdef GEM_EXT_FIFO_RX_STATS_EN
    check("good_frames", 64'(good_frames), 64'(e_good));
    check("bad_frames", 64'(bad_frames), 64'(e_bad));
`endif
    if (buf_ovf) mon_ovf++;
    if (fstat_v) mon_sv++;
  endtask

  // One clock: note the transfer about to happen, clock, update model, compare at negedge.
  task automatic cycle();
    if (rstn && tvalid && tready) begin
      mon_bytes++;
      if (tlast) begin
        mon_lasts++;
        mon_last_pos  = mon_bytes;
        mon_last_data = tdata;
        mon_last_user = tuser;
      end
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic mon_clear();
    mon_bytes = 0; mon_lasts = 0; mon_last_pos = 0; mon_ovf = 0; mon_sv = 0;
    mon_last_data = '0; mon_last_user = 1'b0;
  endtask

  task automatic set_idle();
    wr = 0; sop = 0; eop = 0; err = 0; flush = 0; ovf_in = 0; wdata = '0;
  endtask

  task automatic idle(int n);
    set_idle();
    repeat (n) cycle();
  endtask

  task automatic send(logic [7:0] d, logic s, logic e, logic x);
    set_idle();
    wr = 1; wdata = d; sop = s; eop = e; err = x;
    cycle();
  endtask

  initial begin
    rstn = 1'b0; tready = 1'b0; status = '0;
    set_idle();
    mon_clear();
    @(negedge clk);
    repeat (3) cycle();
    check("reset tvalid", 64'(tvalid), 64'd0);
    check("reset status", 64'(fstat), 64'd0);
    check("reset ovf", 64'(buf_ovf), 64'd0);
    rstn = 1'b1;
    idle(2);

    // 64-byte frame streamed straight through
    tready = 1'b1;
    mon_clear();
    status = 45'h123_4567_89AB;
    for (int i = 0; i < 64; i++) send(8'(i), i == 0, i == 63, 1'b0);
    idle(4);
    check("f64 bytes", 64'(mon_bytes), 64'd64);
    check("f64 lasts", 64'(mon_lasts), 64'd1);
    check("f64 last pos", 64'(mon_last_pos), 64'd64);
    check("f64 last data", 64'(mon_last_data), 64'd63);
    check("f64 tuser", 64'(mon_last_user), 64'd0);
    check("f64 status strobes", 64'(mon_sv), 64'd1);
    check("f64 status", 64'(fstat), 64'h123_4567_89AB);

    // Errored frame
    mon_clear();
    for (int i = 0; i < 3; i++) send(8'(8'h70 + i), i == 0, i == 2, i == 2);
    idle(4);
    check("err bytes", 64'(mon_bytes), 64'd3);
    check("err tuser", 64'(mon_last_user), 64'd1);
`ifdef GEM_EXT_FIFO_RX_STATS_EN
    check("err bad count", 64'(bad_frames), 64'd1);
    check("err good count", 64'(good_frames), 64'd1);
`endif

    // Oversized frame into a stalled stream, then a normal frame
    tready = 1'b0;
    mon_clear();
    for (int i = 0; i < 20; i++) send(8'(8'h40 + i), i == 0, i == 19, 1'b0);
    idle(2);
    check("trunc model depth", 64'(q.size()), 64'd15);
    check("trunc ovf pulses", 64'(mon_ovf), 64'd1);
    tready = 1'b1;
    idle(20);
    check("trunc bytes", 64'(mon_bytes), 64'd15);
    check("trunc lasts", 64'(mon_lasts), 64'd1);
    check("trunc last pos", 64'(mon_last_pos), 64'd15);
    check("trunc last data", 64'(mon_last_data), 64'h4E);
    check("trunc tuser", 64'(mon_last_user), 64'd1);
    mon_clear();
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), i == 0, i == 3, 1'b0);
    idle(3);
    check("next bytes", 64'(mon_bytes), 64'd4);
    check("next last data", 64'(mon_last_data), 64'hC3);
    check("next tuser", 64'(mon_last_user), 64'd0);

    // Flush after 5 bytes, with a simultaneous write that must lose to the flush
    tready = 1'b0;
    mon_clear();
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), i == 0, 1'b0, 1'b0);
    set_idle(); flush = 1; wr = 1; wdata = 8'hAA; cycle();
    idle(2);
    check("flush model depth", 64'(q.size()), 64'd6);
    tready = 1'b1;
    idle(8);
    check("flush bytes", 64'(mon_bytes), 64'd6);
    check("flush last data", 64'(mon_last_data), 64'h00);
    check("flush tuser", 64'(mon_last_user), 64'd1);
    mon_clear();
    send(8'h55, 1'b0, 1'b0, 1'b0);  // discarded in idle
    send(8'h66, 1'b1, 1'b1, 1'b0);  // single-byte frame
    idle(3);
    check("post flush bytes", 64'(mon_bytes), 64'd1);
    check("post flush data", 64'(mon_last_data), 64'h66);

    // sop while a frame is open
    mon_clear();
    for (int i = 0; i < 3; i++) send(8'(8'h20 + i), i == 0, 1'b0, 1'b0);
    send(8'h30, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 1'b0, i == 2, 1'b0);
    idle(3);
    check("sop bytes", 64'(mon_bytes), 64'd4);
    check("sop lasts", 64'(mon_lasts), 64'd1);
    check("sop last data", 64'(mon_last_data), 64'h30);
    check("sop tuser", 64'(mon_last_user), 64'd1);

    // Reset mid-frame
    tready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(8'h90 + i), i == 0, 1'b0, 1'b0);
    rstn = 1'b0;
    set_idle();
    cycle();
    check("reset mid tvalid", 64'(tvalid), 64'd0);
    rstn = 1'b1;
    tready = 1'b1;
    send(8'h93, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("reset no residue", 64'(tvalid), 64'd0);

    // Randomized traffic with varying back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      int rp;
      rp = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 10 : 70;
      for (int c = 0; c < 800; c++) begin
        wr     = ($urandom_range(99) < 70);
        sop    = ($urandom_range(99) < 8);
        eop    = ($urandom_range(99) < 10);
        err    = ($urandom_range(99) < 30);
        flush  = ($urandom_range(99) < 2);
        ovf_in = ($urandom_range(99) < 3);
        wdata  = 8'($urandom());
        status = 45'({$urandom(), $urandom()});
        tready = ($urandom_range(99) < rp);
        cycle();
      end
      if (ph == 1) begin
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
      end
    end
    tready = 1'b1;
    idle(DEPTH + 4);
    check("final drain", 64'(tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
